// File: rtl/l17_pkg.sv
// Shared definitions for the layer-17 write-side z/pixel counter:
// mode encodings, zmax lookup and the control state enum.
package l17_pkg;

    localparam logic [2:0] MODE_1 = 3'd1;
    localparam logic [2:0] MODE_2 = 3'd2;
    localparam logic [2:0] MODE_3 = 3'd3;
    localparam logic [2:0] MODE_4 = 3'd4;

    localparam logic [3:0] ZMAX_QTR  = 4'd3;
    localparam logic [3:0] ZMAX_HALF = 4'd7;
    localparam logic [3:0] ZMAX_FULL = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Same wrap limit the read-side z counter uses for each layer mode.
    function automatic logic [3:0] zmax_of(input logic [2:0] mode);
        logic [3:0] r;
        case (mode)
            MODE_1, MODE_3, MODE_4: r = ZMAX_HALF;
            MODE_2:                 r = ZMAX_QTR;
            default:                r = ZMAX_FULL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l17_wr_skid.sv
// Two-entry valid/ready skid buffer; in_ready is a flop so the
// upstream handshake has no combinational path from downstream.
module l17_wr_skid
    import l17_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              allow_d,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] e0_q, e0_d;
    logic [DATA_W-1:0] e1_q, e1_d;
    logic              rdy_q, rdy_d;
    logic              push;
    logic              pop;

    assign push      = in_valid & rdy_q;
    assign pop       = (cnt_q != 2'd0) & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = e0_q;

    // FIFO occupancy update; e0 is always the head entry.
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_data;
                else               e1_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = in_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_data;
                end
            end
            default: ;
        endcase
        rdy_d = allow_d & (cnt_d < 2'd2);
    end

    // Buffer storage and registered ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            rdy_q <= rdy_d;
        end
    end

endmodule

// File: rtl/z_wr_addr_l17.sv
// Layer-17 write-side z/pixel counter feeding the output fmap memory.
// Optional L17_WR_SKID_EN inserts a registered-ready skid buffer.
module z_wr_addr_l17
    import l17_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PIX    = 196,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        u,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mem_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              z_wrap,
    output logic              busy,
    output logic              done
);

    localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int CNT_W = PIX_W + 5;

    state_e            state_q, state_d;
    logic [2:0]        u_q, u_d;
    logic [3:0]        z_q, z_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              z_wrap_q, z_wrap_d;
    logic              done_q, done_d;

    logic              core_valid;
    logic [DATA_W-1:0] core_data;
    logic              core_ready;
    logic              xfer;
    logic              acc;
    logic [3:0]        zmax;
    logic              last_z;
    logic              last_pix;

    assign core_ready = (state_q == ST_RUN) & (!wr_en_q | mem_ready);
    assign xfer       = core_valid & core_ready;
    assign acc        = wr_en_q & mem_ready;
    assign zmax       = zmax_of(u_q);
    assign last_z     = (z_q == zmax);
    assign last_pix   = (pix_q == PIX_W'(PIX - 1));

`ifdef L17_WR_SKID_EN
    logic [CNT_W-1:0] left_q, left_d;
    logic             allow_d;

    l17_wr_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .allow_d  (allow_d),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(core_valid),
        .out_data (core_data),
        .out_ready(core_ready)
    );

    // Words still to accept upstream, so the buffer never holds
    // anything past the frame's final word.
    always_comb begin
        left_d = left_q;
        if (state_q == ST_IDLE && start) begin
            left_d = CNT_W'(PIX)
                   * (CNT_W'(zmax_of(u)) + CNT_W'(1));
        end else if (in_valid && in_ready) begin
            left_d = left_q - CNT_W'(1);
        end
        allow_d = (state_d == ST_RUN) & (left_d != '0);
    end

    // Upstream word budget register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) left_q <= '0;
        else      left_q <= left_d;
    end
`else
    assign core_valid = in_valid;
    assign core_data  = in_data;
    assign in_ready   = core_ready;
`endif

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        u_d       = u_q;
        z_d       = z_q;
        pix_d     = pix_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        z_wrap_d  = z_wrap_q;
        done_d    = 1'b0;

        if (xfer) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'({pix_q, z_q});
            wr_data_d = core_data;
            z_wrap_d  = last_z;
        end else if (acc) begin
            wr_en_d  = 1'b0;
            z_wrap_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    u_d     = u;
                    z_d     = 4'd0;
                    pix_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (last_z) begin
                        z_d = 4'd0;
                        if (last_pix) state_d = ST_DRAIN;
                        else          pix_d   = pix_q + 1'b1;
                    end else begin
                        z_d = z_q + 4'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (acc) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control FSM with registered write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            u_q       <= 3'd0;
            z_q       <= 4'd0;
            pix_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            z_wrap_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            u_q       <= u_d;
            z_q       <= z_d;
            pix_q     <= pix_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            z_wrap_q  <= z_wrap_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign z_wrap  = z_wrap_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_z_wr_addr_l17.sv
// Directed bench for z_wr_addr_l17: two instances (PIX=4, PIX=2)
// share inputs; writes are checked against hand-derived streams.
module tb_z_wr_addr_l17;

`ifdef L17_WR_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [2:0]  u;
    logic        in_valid;
    logic [15:0] in_data;
    logic        mem_ready;

    logic        ir_a, we_a, zw_a, busy_a, done_a;
    logic [11:0] wa_a;
    logic [15:0] wd_a;
    logic        ir_b, we_b, zw_b, busy_b, done_b;
    logic [11:0] wa_b;
    logic [15:0] wd_b;

    logic        sel;
    logic        m_ir, m_we, m_zw, m_busy, m_done, o_we;
    logic [11:0] m_wa;
    logic [15:0] m_wd;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    z_wr_addr_l17 #(.DATA_W(16), .PIX(4), .ADDR_W(12)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .u(u),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
        .mem_ready(mem_ready), .wr_en(we_a), .wr_addr(wa_a),
        .wr_data(wd_a), .z_wrap(zw_a), .busy(busy_a), .done(done_a)
    );

    z_wr_addr_l17 #(.DATA_W(16), .PIX(2), .ADDR_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .u(u),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
        .mem_ready(mem_ready), .wr_en(we_b), .wr_addr(wa_b),
        .wr_data(wd_b), .z_wrap(zw_b), .busy(busy_b), .done(done_b)
    );

    assign m_ir   = sel ? ir_b   : ir_a;
    assign m_we   = sel ? we_b   : we_a;
    assign m_zw   = sel ? zw_b   : zw_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_wa   = sel ? wa_b   : wa_a;
    assign m_wd   = sel ? wd_b   : wd_a;
    assign o_we   = sel ? we_a   : we_b;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input bit s, input logic [2:0] mode,
                             input int nw, input int zmx,
                             input bit tog, input bit mid,
                             input int abort_at,
                             input logic [15:0] seed);
        int widx = 0;
        int k = 0;
        int cyc = 0;
        int t_x0 = 0;
        int t_w0 = 0;
        int last_wr = 0;
        int z, p;
        bit fin = 0;
        bit stall = 0;
        bit seen_we = 0;
        logic [11:0] sa;
        logic [15:0] sd;
        logic [15:0] expd;

        sel = s;
        @(posedge clk); #1;
        start_a = !s;
        start_b = s;
        u = mode;
        in_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("busy_pre", m_busy, 0);
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;

        while (!fin && cyc < 400) begin
            if (abort_at >= 0 && widx == abort_at) begin
                in_valid = 1'b0;
                rst = 1'b0;
                #1;
                chk("rst_out", {m_ir, m_we, m_zw, m_busy, m_done,
                                m_wa, m_wd}, 0);
                @(negedge clk);
                rst = 1'b1;
                fin = 1;
            end else begin
                in_valid  = (widx < nw);
                in_data   = seed + 16'(widx * 7);
                mem_ready = tog ? cyc[0] : 1'b1;
                if (mid && cyc == 6) begin
                    start_a = !s;
                    start_b = s;
                    u = 3'd2;
                end else begin
                    start_a = 1'b0;
                    start_b = 1'b0;
                end
                @(negedge clk);
                if (cyc == 0) chk("busy_run", m_busy, 1);
                if (stall) begin
                    chk("stall_en", m_we, 1);
                    chk("stall_addr", m_wa, sa);
                    chk("stall_data", m_wd, sd);
                    stall = 0;
                end
                if (in_valid && m_ir) begin
                    if (widx == 0) t_x0 = cyc;
                    widx++;
                end
                if (m_we && !seen_we) begin
                    seen_we = 1;
                    t_w0 = cyc;
                    chk("latency", cyc - t_x0, LAT);
                end
                if (m_we) begin
                    if (mem_ready) begin
                        z = k % (zmx + 1);
                        p = k / (zmx + 1);
                        expd = seed + 16'(k * 7);
                        chk("addr", m_wa, p * 16 + z);
                        chk("data", m_wd, expd);
                        chk("zwrap", m_zw, (z == zmx) ? 1 : 0);
                        last_wr = cyc;
                        k++;
                    end else begin
                        stall = 1;
                        sa = m_wa;
                        sd = m_wd;
`ifndef L17_WR_SKID_EN
                        chk("ready_low", m_ir, 0);
`endif
                    end
                end
                if (m_done) begin
                    chk("done_cnt", k, nw);
                    chk("done_time", cyc, last_wr + 1);
                    if (!tog) chk("b2b", last_wr - t_w0, nw - 1);
                    fin = 1;
                end
                cyc++;
                @(posedge clk); #1;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", m_busy, 0);
        chk("idle_done", m_done, 0);
        chk("other_quiet", o_we, 0);
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        u = 3'd0;
        in_valid = 1'b0;
        in_data = 16'h0;
        mem_ready = 1'b0;
        sel = 1'b0;
        #2;
        chk("rst_a", {ir_a, we_a, zw_a, busy_a, done_a, wa_a, wd_a}, 0);
        chk("rst_b", {ir_b, we_b, zw_b, busy_b, done_b, wa_b, wd_b}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data = 16'hDEAD;
            mem_ready = 1'b1;
            @(negedge clk);
            chk("idle_wr", {we_a, we_b}, 0);
            chk("idle_rdy", {ir_a, ir_b}, 0);
            chk("idle_bsy", {busy_a, busy_b}, 0);
        end
        in_valid = 1'b0;

        run_frame(1'b0, 3'd2, 16, 3, 1'b0, 1'b0, -1, 16'h1000);
        run_frame(1'b1, 3'd0, 32, 15, 1'b0, 1'b0, -1, 16'h2000);
        run_frame(1'b0, 3'd1, 32, 7, 1'b1, 1'b1, -1, 16'h3000);
        run_frame(1'b0, 3'd1, 32, 7, 1'b0, 1'b0, 13, 16'h4000);
        run_frame(1'b0, 3'd4, 32, 7, 1'b0, 1'b0, -1, 16'h5000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/z_wr_addr_l17.md
# z_wr_addr_l17

Write-side z/pixel loop counter for layer 17 of the SqueezeNext accelerator. Accepts one result word per handshake from the PE array output and writes it to the output feature-map memory. Tracks output channel slot `z` and pixel index, wrapping `z` at the same mode-dependent limits the read-side z counter uses, so written data lands at the address the read side expects. Raises a per-pixel wrap pulse and a frame-done pulse.

## Interface
- `DATA_W`, default 16: result word width.
- `PIX`, default 196: pixels per frame (14x14).
- `ADDR_W`, default 12: write address width; must be ≥ clog2(PIX)+4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
- `u`  in  3  layer mode, sampled on `start`.
- `in_valid`  in  1  result word valid from the PE array.
- `in_data`  in  DATA_W  result word.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `mem_ready`  in  1  output memory accepts the write this cycle.
- `wr_en`  out  1  write request; held until `mem_ready`.
- `wr_addr`  out  ADDR_W  pix*16 + z.
- `wr_data`  out  DATA_W  word being written.
- `z_wrap`  out  1  asserted with the write whose z equals zmax.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- `zmax` comes from the latched `u_q`:
  - 7 when `u_q` ∈ {1,3,4}.
  - 3 when `u_q` = 2.
  - 15 otherwise, including 0 and 5–7.
- State IDLE:
  - `in_ready` = 0.
  - On `start`: `u_q` ← `u`, z ← 0, pix ← 0, go to RUN.
- State RUN:
  - `in_ready` = !`wr_en` | `mem_ready`.
  - A transfer is `in_valid` & `in_ready`. On a transfer the output register loads `wr_en`=1, `wr_addr`={pix,z}, `wr_data`=`in_data`, `z_wrap`=(z==zmax).
  - z advances on each transfer. At zmax it returns to 0 and pix increments.
  - The transfer with z==zmax and pix==PIX-1 moves the state to DRAIN.
- Output register:
  - Holds `wr_en`, `wr_addr`, `wr_data` and `z_wrap` while `mem_ready`=0.
  - Clears `wr_en` and `z_wrap` on acceptance when no new transfer occurs in the same cycle.
- State DRAIN:
  - `in_ready` = 0.
  - When the final write is accepted (`wr_en` & `mem_ready`), go to DONE.
- State DONE:
  - `done` = 1 for one cycle, then IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `in_valid` outside RUN.
- Address arithmetic: z is 4 bits and pix is clog2(PIX) bits. Writes never reach slots z > zmax.

## Timing
- Reset values: `in_ready`, `wr_en`, `z_wrap`, `busy` and `done` are 0. `wr_addr` and `wr_data` are 0. State is IDLE, z=0, pix=0, `u_q`=0.
- Reset mid-frame discards the pending write with no done pulse.
- `start` at cycle N → `busy`=1 and `in_ready` may be 1 at N+1.
- Latency: a transfer at cycle N puts `wr_en` at N+1 (N+2 with skid).
- With `mem_ready` held 1 the block sustains one write per cycle.
- A simultaneous transfer and acceptance in the same cycle replaces the output register. There is no bubble.
- Final write accepted at cycle M → `done` at M+1 and IDLE at M+2.
- `start` coinciding with `done` is ignored.

## Configuration
- `L17_WR_SKID_EN` defined:
  - A two-entry skid buffer sits between `in_*` and the counter.
  - `in_ready` comes straight from a flop, with no combinational path from `mem_ready`.
  - Adds one cycle of latency.
  - The buffer must be empty before leaving RUN.
- `L17_WR_SKID_EN` undefined: `in_ready` is combinational as described in Operation.
- The sequence of addresses and data written is identical in both builds.

## Structure
- Shared package `l17_pkg`:
  - Mode encodings.
  - `zmax` lookup function.
  - State enum (IDLE/RUN/DRAIN/DONE).
- Sub-module `l17_wr_skid`: the valid/ready skid buffer, instantiated only under `L17_WR_SKID_EN`.

## Test plan
- u=2, PIX=4, 16 back-to-back words, `mem_ready`=1 → addresses 0–3, 16–19, 32–35, 48–51; `z_wrap` on every 4th write; `done` one cycle after the 16th write.
- u=0, PIX=2, 32 words → addresses 0–15 then 16–31; `z_wrap` at addresses 15 and 31.
- u=1, `mem_ready` toggling 1/0 each cycle → `wr_en`/`wr_addr`/`wr_data` stable while stalled; no word lost or duplicated; `in_ready` low while the register is full and not accepted.
- `start` pulsed mid-frame and `in_valid` asserted in IDLE → no state change and no writes.
- `rst` low at pix=1, z=5 → all outputs 0 the same cycle; a new `start` with u=4 writes from address 0 with zmax=7.
- Repeat the first scenario with `L17_WR_SKID_EN` → same write stream, one extra cycle of latency, `in_ready` registered.
